mdu_iter_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers.
- Replaces the single-cycle 64-bit ALU product path and the free-running HI/LO register pair in the EX stage.
- Computes MULT/MULTU/DIV/DIVU iteratively over DATA_W cycles and exposes busy/ready so the hazard unit can stall dependent MFHI/MFLO and later MDU ops.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_step_core.sv | 52 +++++
 rtl/mdu_iter_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mdu_iter_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the iterative multiply/divide unit.
//                Holds the op encoding, the controller state enum and the
//                default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    // Op encoding as presented by the EX stage
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;
    localparam logic [2:0] MDU_MSUB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_step_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_step_core
//  Description : Combinational single iteration of the MDU datapath.
//                is_div=0 : radix-2 shift-add multiply step. acc holds
//                           {partial product, remaining multiplier}.
//                is_div=1 : restoring divide step. acc holds
//                           {partial remainder, remaining dividend/quotient}.
//  Ports       : is_div  - selects divide step
//                acc_in  - 2*DATA_W working accumulator
//                opnd    - multiplicand or divisor magnitude
//                acc_out - accumulator after one iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_step_core
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc_in,
    input  logic [DATA_W-1:0]     opnd,
    output logic [2*DATA_W-1:0]   acc_out
);

    logic [DATA_W:0] w_add_sum;
    logic [DATA_W:0] w_rem_shift;
    logic [DATA_W:0] w_trial;

    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, keep
        // the carry and shift the whole accumulator right by one.
        w_add_sum   = {1'b0, acc_in[2*DATA_W-1:DATA_W]}
                    + (acc_in[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
        // Divide: remainder shifted left with the next dividend bit; one
        // extra bit so the trial subtract sign is exact.
        w_rem_shift = acc_in[2*DATA_W-1:DATA_W-1];
        w_trial     = w_rem_shift - {1'b0, opnd};

        if (is_div) begin
            if (!w_trial[DATA_W]) begin
                acc_out = {w_trial[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b1};
            end else begin
                acc_out = {w_rem_shift[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_out = {w_add_sum, acc_in[DATA_W-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Operands
//                are reduced to magnitudes at accept, DATA_W iterations run
//                in RUN, signs are restored and HI/LO written in FIX.
//                Optional macro MDU_MACC_EN enables MADD/MSUB accumulate.
//  Ports       : Clk, Reset (sync, active-low)
//                start_valid/start_ready - op handshake (ready only in IDLE)
//                op, src_a, src_b        - operation and operands
//                flush                   - cancel in-flight / offered op
//                busy, done, div0        - status
//                hi, lo                  - architectural HI/LO
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0]       acc_q, acc_d;
    logic [DATA_W-1:0]         opnd_q, opnd_d;
    logic                      is_div_q, is_div_d;
    logic                      neg_res_q, neg_res_d;
    logic                      neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]         hi_q, hi_d;
    logic [DATA_W-1:0]         lo_q, lo_d;
    logic                      done_q, done_d;
    logic                      div0_q, div0_d;
`ifdef MDU_MACC_EN
    logic                      macc_q, macc_d;
    logic                      msub_q, msub_d;
`endif

    logic                      w_op_ok;
    logic                      w_accept;
    logic                      w_signed;
    logic                      w_op_div;
    logic [DATA_W-1:0]         w_mag_a;
    logic [DATA_W-1:0]         w_mag_b;
    logic [2*DATA_W-1:0]       w_step;
    logic [2*DATA_W-1:0]       w_prod;
    logic [DATA_W-1:0]         w_quot;
    logic [DATA_W-1:0]         w_rem;

    mdu_step_core #(.DATA_W(DATA_W)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (w_step)
    );

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div0        = div0_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    always_comb begin
`ifdef MDU_MACC_EN
        w_op_ok  = 1'b1;
        w_signed = (op == MDU_MULT) || (op == MDU_DIV)
                || (op == MDU_MADD) || (op == MDU_MSUB);
`else
        w_op_ok  = (op != MDU_MADD) && (op != MDU_MSUB);
        w_signed = (op == MDU_MULT) || (op == MDU_DIV);
`endif
        w_accept = start_valid && start_ready && !flush && w_op_ok;
        w_op_div = (op == MDU_DIV) || (op == MDU_DIVU);
        w_mag_a  = (w_signed && src_a[DATA_W-1]) ? (~src_a + 1'b1) : src_a;
        w_mag_b  = (w_signed && src_b[DATA_W-1]) ? (~src_b + 1'b1) : src_b;

        // Sign restoration for the FIX stage
        w_prod   = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        w_quot   = neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
        w_rem    = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1)
                             : acc_q[2*DATA_W-1:DATA_W];

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
`ifdef MDU_MACC_EN
        macc_d    = macc_q;
        msub_d    = msub_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    div0_d = w_op_div && (src_b == '0);
                    if (op == MDU_MTHI) begin
                        hi_d   = src_a;
                        done_d = 1'b1;
                    end else if (op == MDU_MTLO) begin
                        lo_d   = src_a;
                        done_d = 1'b1;
                    end else begin
                        acc_d     = {{DATA_W{1'b0}}, w_mag_a};
                        opnd_d    = w_mag_b;
                        is_div_d  = w_op_div;
                        neg_res_d = w_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        // Remainder takes the dividend's sign
                        neg_rem_d = w_signed && src_a[DATA_W-1];
                        cnt_d     = CNT_W'(DATA_W - 1);
                        state_d   = ST_RUN;
`ifdef MDU_MACC_EN
                        macc_d    = (op == MDU_MADD) || (op == MDU_MSUB);
                        msub_d    = (op == MDU_MSUB);
`endif
                    end
                end
            end

            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Zero divisor yields an all-ones quotient; the
                        // remainder path already reproduces src_a.
                        lo_d = div0_q ? {DATA_W{1'b1}} : w_quot;
                        hi_d = w_rem;
                    end else begin
`ifdef MDU_MACC_EN
                        if (macc_q) begin
                            if (msub_q) begin
                                {hi_d, lo_d} = {hi_q, lo_q} - w_prod;
                            end else begin
                                {hi_d, lo_d} = {hi_q, lo_q} + w_prod;
                            end
                        end else begin
                            {hi_d, lo_d} = w_prod;
                        end
`else
                        {hi_d, lo_d} = w_prod;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
`ifdef MDU_MACC_EN
            macc_q    <= 1'b0;
            msub_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
`ifdef MDU_MACC_EN
            macc_q    <= macc_d;
            msub_q    <= msub_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_iter_unit
//  Description : Directed self-checking bench for mdu_iter_unit (DATA_W=32).
//                Accumulate vectors are compiled in when MDU_MACC_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         start_valid = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         start_ready;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mdu_iter_unit #(.DATA_W(W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div0        (div0),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single cycle; returns 1ns after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        start_valid = 1'b1;
        op          = o;
        src_a       = a;
        src_b       = b;
        @(posedge Clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge Clk);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int lat;
        issue(o, a, b);
        chk_eq({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk_eq({tag, "_latency"}, 64'(lat), 64'd33);
        chk_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        chk_eq({tag, "_ready"}, 64'(start_ready), 64'd1);
        @(posedge Clk);
        #1;
        chk_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  lat;
        logic seen;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk_eq("rst_hi", 64'(hi), 64'd0);
        chk_eq("rst_lo", 64'(lo), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_done", 64'(done), 64'd0);
        chk_eq("rst_div0", 64'(div0), 64'd0);
        chk_eq("rst_ready", 64'(start_ready), 64'd1);
        Reset = 1'b1;

        // Arithmetic vectors
        run_op("mult",   MDU_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu",  MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
        run_op("div",    MDU_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",   MDU_DIVU,  32'd7, 32'd2, 32'd1, 32'd3);
        run_op("divu_big", MDU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);
        run_op("div_ovf", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Divide by zero and div0 clearing
        run_op("divu0",  MDU_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        chk_eq("divu0_flag", 64'(div0), 64'd1);
        issue(MDU_MULT, 32'd2, 32'd3);
        chk_eq("div0_clear", 64'(div0), 64'd0);
        wait_done(lat);
        chk_eq("mult23_lo", 64'(lo), 64'd6);

        // MTHI: same-edge write, done pulse, no busy
        issue(MDU_MTHI, 32'h1234, 32'h0);
        chk_eq("mthi_hi", 64'(hi), 64'h1234);
        chk_eq("mthi_busy", 64'(busy), 64'd0);
        chk_eq("mthi_done", 64'(done), 64'd1);
        @(posedge Clk);
        #1;
        chk_eq("mthi_done_end", 64'(done), 64'd0);

`ifndef MDU_MACC_EN
        // Accumulate ops are ignored without the feature
        @(negedge Clk);
        start_valid = 1'b1;
        op          = MDU_MADD;
        src_a       = 32'd9;
        src_b       = 32'd9;
        #1;
        chk_eq("madd_off_ready", 64'(start_ready), 64'd1);
        @(posedge Clk);
        #1;
        start_valid = 1'b0;
        chk_eq("madd_off_busy", 64'(busy), 64'd0);
        chk_eq("madd_off_hilo", {hi, lo}, {32'h1234, 32'd6});
        @(posedge Clk);
        #1;
        chk_eq("madd_off_done", 64'(done), 64'd0);
`endif

        // Flush mid-run
        issue(MDU_MTHI, 32'h55, 32'h0);
        issue(MDU_MTLO, 32'h55, 32'h0);
        issue(MDU_MULT, 32'd3, 32'd4);
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        flush = 1'b1;
        @(posedge Clk);
        #1;
        flush = 1'b0;
        chk_eq("flush_busy", 64'(busy), 64'd0);
        chk_eq("flush_ready", 64'(start_ready), 64'd1);
        chk_eq("flush_hilo", {hi, lo}, {32'h55, 32'h55});
        seen = 1'b0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk_eq("flush_no_done", 64'(seen), 64'd0);

        // Flush together with start: nothing accepted
        @(negedge Clk);
        start_valid = 1'b1;
        flush       = 1'b1;
        op          = MDU_MULT;
        src_a       = 32'd5;
        src_b       = 32'd5;
        @(posedge Clk);
        #1;
        start_valid = 1'b0;
        flush       = 1'b0;
        chk_eq("flush_start_busy", 64'(busy), 64'd0);
        chk_eq("flush_start_lo", 64'(lo), 64'h55);

        // start_valid while busy is ignored
        issue(MDU_MULTU, 32'd3, 32'd5);
        @(negedge Clk);
        start_valid = 1'b1;
        op          = MDU_MULT;
        src_a       = 32'd7;
        src_b       = 32'd7;
        #1;
        chk_eq("busy_ready", 64'(start_ready), 64'd0);
        repeat (5) @(posedge Clk);
        #1;
        start_valid = 1'b0;
        wait_done(lat);
        chk_eq("busy_done_seen", 64'(done), 64'd1);
        chk_eq("busy_hilo", {hi, lo}, {32'd0, 32'd15});
        repeat (40) @(posedge Clk);
        #1;
        chk_eq("busy_second_ignored", {hi, lo}, {32'd0, 32'd15});

`ifdef MDU_MACC_EN
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'd10, 32'd0);
        run_op("madd", MDU_MADD, 32'd3, 32'd4, 32'd0, 32'd22);
        run_op("msub", MDU_MSUB, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(MDU_MADD, 32'd3, 32'd4);
`else
        issue(MDU_MULT, 32'd3, 32'd4);
`endif
        // Reset mid-operation
        issue(MDU_DIVU, 32'd9, 32'd0);
        wait_done(lat);
        issue(MDU_MULT, 32'd6, 32'd7);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        chk_eq("midrst_hilo", {hi, lo}, 64'd0);
        chk_eq("midrst_busy", 64'(busy), 64'd0);
        chk_eq("midrst_done", 64'(done), 64'd0);
        chk_eq("midrst_div0", 64'(div0), 64'd0);
        chk_eq("midrst_ready", 64'(start_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
